// File: rtl/multiplexor_arbitrado_pkg.sv
// Shared constants for the arbitrated multiplexer and the control unit that drives Modo.
// The control unit imports the same package, so both sides agree on the Modo encoding.
package multiplexor_arbitrado_pkg;

    localparam logic MODO_FIJO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

    typedef logic modo_t;

endpackage : multiplexor_arbitrado_pkg

// File: rtl/arbitro_round_robin.sv
// Round-robin arbiter: one-hot grant to the first requester at or above puntero, wrapping around.
// The wrap is resolved by scanning a doubled request vector whose lower copy is masked below puntero.
module arbitro_round_robin #(
    parameter  int CANALES = 4,
    localparam int SEL_W   = $clog2(CANALES)
) (
    input  logic [CANALES-1:0] solicitudes,
    input  logic [SEL_W-1:0]   puntero,
    input  logic               habilitar,
    output logic [CANALES-1:0] concesion
);

    logic [2*CANALES-1:0] doble_s;
    logic [2*CANALES-1:0] mascara_s;
    logic [2*CANALES-1:0] enmascarada_s;
    logic [2*CANALES-1:0] primera_s;

    // Upper copy stays unmasked so a request below puntero is still found after the wrap.
    always_comb begin
        mascara_s = '0;
        for (int j = 0; j < 2*CANALES; j++) begin
            mascara_s[j] = (j >= CANALES) || (j >= int'(puntero));
        end
        doble_s       = {solicitudes, solicitudes};
        enmascarada_s = doble_s & mascara_s;
        primera_s     = enmascarada_s & (~enmascarada_s + (2*CANALES)'(1));
    end

    // Fold both halves back onto the channel range; only one bit of primera_s can be set.
    always_comb begin
        concesion = '0;
        if (habilitar) begin
            concesion = primera_s[CANALES-1:0] | primera_s[2*CANALES-1:CANALES];
        end else begin
            concesion = '0;
        end
    end

endmodule : arbitro_round_robin

// File: rtl/multiplexor_arbitrado.sv
// N-channel, W-bit multiplexer with valid/ready on every channel and a single registered output slot.
// The source is picked by a fixed selector or by a round-robin arbiter; one word per cycle, one cycle latency.
module multiplexor_arbitrado
    import multiplexor_arbitrado_pkg::*;
#(
    parameter  int ANCHO   = 16,
    parameter  int CANALES = 4,
    localparam int SEL_W   = $clog2(CANALES)
) (
    input  logic                       Reloj,
    input  logic                       Reset,
    input  logic [CANALES*ANCHO-1:0]   Entradas,
    input  logic [CANALES-1:0]         EntradaValida,
    output logic [CANALES-1:0]         EntradaListo,
    input  logic                       Modo,
    input  logic [SEL_W-1:0]           Selector,
    output logic [ANCHO-1:0]           Salida,
    output logic                       SalidaValida,
    input  logic                       SalidaListo,
    output logic [SEL_W-1:0]           CanalSalida
);

    logic [ANCHO-1:0]   salida_d,  salida_q;
    logic               valida_d,  valida_q;
    logic [SEL_W-1:0]   canal_d,   canal_q;
    logic [SEL_W-1:0]   puntero_d, puntero_q;

    logic               carga_s;
    logic [CANALES-1:0] concesion_rr_s;
    logic [CANALES-1:0] listo_s;
    logic [CANALES-1:0] transfer_s;
    logic               hay_transfer_s;
    logic [SEL_W-1:0]   indice_s;
    logic [ANCHO-1:0]   dato_s;

    assign carga_s = !valida_q || SalidaListo;

    arbitro_round_robin #(
        .CANALES (CANALES)
    ) u_arbitro (
        .solicitudes (EntradaValida),
        .puntero     (puntero_q),
        .habilitar   (carga_s),
        .concesion   (concesion_rr_s)
    );

    // Grant vector: in fixed mode ready ignores valid, and an out-of-range selector matches no channel.
    always_comb begin
        listo_s = '0;
        if (Modo == MODO_RR) begin
            listo_s = concesion_rr_s;
        end else begin
            for (int i = 0; i < CANALES; i++) begin
                listo_s[i] = carga_s && (int'(Selector) == i);
            end
        end
    end

    // At most one channel transfers per cycle, so OR-folding is an exact one-hot encode and data select.
    always_comb begin
        transfer_s     = EntradaValida & listo_s;
        hay_transfer_s = |transfer_s;
        indice_s       = '0;
        dato_s         = '0;
        for (int i = 0; i < CANALES; i++) begin
            indice_s = indice_s | (transfer_s[i] ? SEL_W'(i) : '0);
            dato_s   = dato_s | ({ANCHO{transfer_s[i]}} & Entradas[i*ANCHO +: ANCHO]);
        end
    end

    // Output slot and pointer next state; Salida and CanalSalida keep their value once consumed.
    always_comb begin
        salida_d  = salida_q;
        valida_d  = valida_q;
        canal_d   = canal_q;
        puntero_d = puntero_q;
        if (hay_transfer_s) begin
            salida_d = dato_s;
            canal_d  = indice_s;
            valida_d = 1'b1;
            if (Modo == MODO_RR) begin
                puntero_d = (indice_s == SEL_W'(CANALES-1)) ? '0 : indice_s + SEL_W'(1);
            end else begin
                puntero_d = puntero_q;
            end
        end else if (SalidaListo) begin
            valida_d = 1'b0;
        end else begin
            valida_d = valida_q;
        end
    end

    // State registers, cleared asynchronously so a word held at reset is dropped.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            salida_q  <= '0;
            valida_q  <= 1'b0;
            canal_q   <= '0;
            puntero_q <= '0;
        end else begin
            salida_q  <= salida_d;
            valida_q  <= valida_d;
            canal_q   <= canal_d;
            puntero_q <= puntero_d;
        end
    end

    assign EntradaListo = listo_s;
    assign Salida       = salida_q;
    assign SalidaValida = valida_q;
    assign CanalSalida  = canal_q;

endmodule : multiplexor_arbitrado

// File: tb/tb_multiplexor_arbitrado.sv
// Directed bench: a 5-channel instance for reset, fixed, sparse round-robin, backpressure and mode
// switching, plus a 4-channel instance for round-robin fairness.
module tb_multiplexor_arbitrado;

    logic        Reloj = 1'b0;
    logic        Reset;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [79:0] ent5;
    logic [4:0]  val5, listo5;
    logic        modo5, sv5, sl5;
    logic [2:0]  sel5, canal5;
    logic [15:0] sal5;

    logic [63:0] ent4;
    logic [3:0]  val4, listo4;
    logic        modo4, sv4, sl4;
    logic [1:0]  sel4, canal4;
    logic [15:0] sal4;

    int          rr_exp[4] = '{1, 4, 1, 4};

    always #5 Reloj = ~Reloj;

    multiplexor_arbitrado #(.ANCHO(16), .CANALES(5)) u5 (
        .Reloj(Reloj), .Reset(Reset), .Entradas(ent5), .EntradaValida(val5),
        .EntradaListo(listo5), .Modo(modo5), .Selector(sel5), .Salida(sal5),
        .SalidaValida(sv5), .SalidaListo(sl5), .CanalSalida(canal5)
    );

    multiplexor_arbitrado #(.ANCHO(16), .CANALES(4)) u4 (
        .Reloj(Reloj), .Reset(Reset), .Entradas(ent4), .EntradaValida(val4),
        .EntradaListo(listo4), .Modo(modo4), .Selector(sel4), .Salida(sal4),
        .SalidaValida(sv4), .SalidaListo(sl4), .CanalSalida(canal4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Reloj);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        ent5 = '0; val5 = '0; modo5 = 1'b0; sel5 = '0; sl5 = 1'b1;
        ent4 = '0; val4 = '0; modo4 = 1'b0; sel4 = '0; sl4 = 1'b1;
        for (int i = 0; i < 5; i++) ent5[i*16 +: 16] = 16'hA000 + 16'(i);
        for (int i = 0; i < 4; i++) ent4[i*16 +: 16] = 16'hB000 + 16'(i);
        tick;
        tick;
        check("rst_salida", 32'(sal5), 32'h0);
        check("rst_valida", 32'(sv5), 32'h0);
        check("rst_canal", 32'(canal5), 32'h0);
        Reset = 1'b0;

        // Load a word, then reset while it is held.
        sel5 = 3'd1; val5 = 5'b00010;
        tick;
        check("pre_salida", 32'(sal5), 32'hA001);
        check("pre_canal", 32'(canal5), 32'd1);
        check("pre_valida", 32'(sv5), 32'h1);
        #1 Reset = 1'b1;
        #1;
        check("midrst_salida", 32'(sal5), 32'h0);
        check("midrst_valida", 32'(sv5), 32'h0);
        check("midrst_canal", 32'(canal5), 32'h0);
        #1 Reset = 1'b0;

        // Fixed mode right after reset release.
        ent5[32 +: 16] = 16'hBEEF; sel5 = 3'd2; val5 = 5'b00100;
        #1;
        check("fix_listo", 32'(listo5), 32'b00100);
        tick;
        check("fix_salida", 32'(sal5), 32'hBEEF);
        check("fix_canal", 32'(canal5), 32'd2);
        check("fix_valida", 32'(sv5), 32'h1);
        ent5[32 +: 16] = 16'hA002;

        // Round-robin with sparse requests on channels 1 and 4.
        modo5 = 1'b1; val5 = 5'b10010;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rr_sparse_canal", 32'(canal5), 32'(rr_exp[k]));
            check("rr_sparse_salida", 32'(sal5), 32'hA000 + 32'(rr_exp[k]));
            check("rr_sparse_valida", 32'(sv5), 32'h1);
        end
        val5 = 5'b01000;
        tick;
        check("rr_to4_canal", 32'(canal5), 32'd3);
        val5 = 5'b00001;
        #1;
        check("rr_wrap_listo", 32'(listo5), 32'b00001);
        tick;
        check("rr_wrap_canal", 32'(canal5), 32'd0);
        check("rr_wrap_salida", 32'(sal5), 32'hA000);

        // Backpressure with every channel requesting.
        val5 = 5'b11111; sl5 = 1'b0;
        #1;
        check("bp_listo0", 32'(listo5), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("bp_salida", 32'(sal5), 32'hA000);
            check("bp_canal", 32'(canal5), 32'd0);
            check("bp_valida", 32'(sv5), 32'h1);
            check("bp_listo", 32'(listo5), 32'h0);
        end
        sl5 = 1'b1;
        #1;
        check("bp_rel_listo", 32'(listo5), 32'b00010);
        tick;
        check("bp_rel_canal", 32'(canal5), 32'd1);
        check("bp_rel_salida", 32'(sal5), 32'hA001);

        // Out-of-range selector grants nothing; the held word drains.
        modo5 = 1'b0; sel5 = 3'd7;
        #1;
        check("sel7_listo", 32'(listo5), 32'h0);
        tick;
        check("sel7_valida", 32'(sv5), 32'h0);
        check("sel7_salida", 32'(sal5), 32'hA001);
        check("sel7_canal", 32'(canal5), 32'd1);
        sel5 = 3'd3;
        #1;
        check("sel3_listo", 32'(listo5), 32'b01000);
        tick;
        check("sel3_canal", 32'(canal5), 32'd3);
        check("sel3_salida", 32'(sal5), 32'hA003);

        // Switch to round-robin while stalled; resume from the stored pointer (2).
        sl5 = 1'b0; modo5 = 1'b1;
        tick;
        check("sw_hold_salida", 32'(sal5), 32'hA003);
        check("sw_hold_canal", 32'(canal5), 32'd3);
        check("sw_hold_valida", 32'(sv5), 32'h1);
        sl5 = 1'b1;
        #1;
        check("sw_listo", 32'(listo5), 32'b00100);
        tick;
        check("sw_canal2", 32'(canal5), 32'd2);
        check("sw_salida2", 32'(sal5), 32'hA002);
        tick;
        check("sw_canal3", 32'(canal5), 32'd3);
        tick;
        check("sw_canal4", 32'(canal5), 32'd4);
        tick;
        check("sw_canal0", 32'(canal5), 32'd0);
        val5 = 5'b00000;
        tick;
        check("drain_valida", 32'(sv5), 32'h0);
        check("drain_salida", 32'(sal5), 32'hA000);

        // Fairness on the 4-channel instance.
        modo4 = 1'b1; val4 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick;
            check("fair_canal", 32'(canal4), 32'(k % 4));
            check("fair_salida", 32'(sal4), 32'hB000 + 32'(k % 4));
            check("fair_valida", 32'(sv4), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multiplexor_arbitrado
